// File: rtl/shifter_pkg.sv
// Shared types and elaboration helpers for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic [1:0] {
        SRL  = 2'd0,
        SRA  = 2'd1,
        SLL  = 2'd2,
        RSVD = 2'd3
    } shift_mode_e;

    // Barrel levels carried by each register stage; the last stage may get fewer.
    function automatic int levels_per_stage(input int levels, input int stages);
        return (levels + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/shifter_pipe_if.sv
// Operand/result stream bundle between a producer and the shifter pipeline.
interface shifter_pipe_if
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 48,
    parameter int SHW    = 8,
    parameter int USER_W = 8
) ();

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [SHW-1:0]    in_shamt;
    shift_mode_e       in_mode;
    logic [USER_W-1:0] in_user;

    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_lost;
    logic [USER_W-1:0] out_user;

    modport master (
        output in_valid, in_data, in_shamt, in_mode, in_user, out_ready,
        input  in_ready, out_valid, out_data, out_lost, out_user
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, in_user, out_ready,
        output in_ready, out_valid, out_data, out_lost, out_user
    );

endinterface

// File: rtl/shifter_level.sv
// One combinational barrel level: shifts by AMT when enabled and folds the
// discarded bits into the running lost flag.
module shifter_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  shift_mode_e      mode_i,
    input  logic             en_i,
    input  logic             lost_i,
    output logic [WIDTH-1:0] data_o,
    output logic             lost_o
);

    always_comb begin
        data_o = data_i;
        lost_o = lost_i;
        if (en_i) begin
            case (mode_i)
                SLL: begin
                    data_o = data_i << AMT;
                    lost_o = lost_i | (|data_i[WIDTH-1 -: AMT]);
                end
                SRA: begin
                    data_o = $signed(data_i) >>> AMT;
                    lost_o = lost_i | (|data_i[AMT-1:0]);
                end
                default: begin
                    data_o = data_i >> AMT;
                    lost_o = lost_i | (|data_i[AMT-1:0]);
                end
            endcase
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter with lost-bit flag and valid/ready flow control;
// barrel levels are spread over PIPE_STAGES register stages.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH       = 48,
    parameter int SHW         = 8,
    parameter int PIPE_STAGES = 2,
    parameter int USER_W      = 8
) (
    input logic           clk,
    input logic           rst_n,
    shifter_pipe_if.slave bus
);

    localparam int L   = $clog2(WIDTH);
    localparam int LPS = levels_per_stage(L, PIPE_STAGES);

    logic             sat;
    logic [WIDTH-1:0] sat_data;
    logic             sat_lost;
    logic [L-1:0]     sat_shamt;

    // Saturated SRA keeps the sign bit in every result position, so only the
    // magnitude bits count as lost.
    always_comb begin
        sat       = bus.in_shamt >= SHW'(WIDTH);
        sat_data  = bus.in_data;
        sat_lost  = 1'b0;
        sat_shamt = bus.in_shamt[L-1:0];
        if (sat) begin
            sat_shamt = '0;
            if (bus.in_mode == SRA) begin
                sat_data = {WIDTH{bus.in_data[WIDTH-1]}};
                sat_lost = |bus.in_data[WIDTH-2:0];
            end else begin
                sat_data = '0;
                sat_lost = |bus.in_data;
            end
        end
    end

    for (genvar j = 0; j < L; j++) begin : g_lvl
        localparam int G = j / LPS;
        localparam int K = L - 1 - j;

        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] dout;
        logic             lin;
        logic             lout;
        logic             en;
        shift_mode_e      mode;

        if (G == 0) begin : g_ctl
            assign mode = bus.in_mode;
            assign en   = sat_shamt[K];
        end else begin : g_ctl
            assign mode = g_stage[G-1].mode_q;
            assign en   = g_stage[G-1].shamt_q[K];
        end

        if (j == 0) begin : g_src
            assign din = sat_data;
            assign lin = sat_lost;
        end else if (j == G * LPS) begin : g_src
            assign din = g_stage[G-1].data_q;
            assign lin = g_stage[G-1].lost_q;
        end else begin : g_src
            assign din = g_lvl[j-1].dout;
            assign lin = g_lvl[j-1].lout;
        end

        shifter_level #(
            .WIDTH (WIDTH),
            .AMT   (1 << K)
        ) u_level (
            .data_i (din),
            .mode_i (mode),
            .en_i   (en),
            .lost_i (lin),
            .data_o (dout),
            .lost_o (lout)
        );
    end

    for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
        localparam int LO = g * LPS;
        localparam int HI = ((g + 1) * LPS < L) ? (g + 1) * LPS - 1 : L - 1;

        logic              en;
        logic              up_valid;
        logic              valid_q;
        logic [WIDTH-1:0]  data_q;
        logic [WIDTH-1:0]  data_d;
        logic              lost_q;
        logic              lost_d;
        shift_mode_e       mode_q;
        shift_mode_e       mode_d;
        logic [L-1:0]      shamt_q;
        logic [L-1:0]      shamt_d;
        logic [USER_W-1:0] user_q;
        logic [USER_W-1:0] user_d;
        logic              unused_ctl;

        if (g == 0) begin : g_up
            assign up_valid = bus.in_valid;
            assign user_d   = bus.in_user;
            assign mode_d   = bus.in_mode;
            assign shamt_d  = sat_shamt;
        end else begin : g_up
            assign up_valid = g_stage[g-1].valid_q;
            assign user_d   = g_stage[g-1].user_q;
            assign mode_d   = g_stage[g-1].mode_q;
            assign shamt_d  = g_stage[g-1].shamt_q;
        end

        // A stage with no levels of its own just retimes the previous result.
        if (LO < L) begin : g_res
            assign data_d = g_lvl[HI].dout;
            assign lost_d = g_lvl[HI].lout;
        end else begin : g_res
            assign data_d = g_stage[g-1].data_q;
            assign lost_d = g_stage[g-1].lost_q;
        end

        if (g == PIPE_STAGES - 1) begin : g_en
            assign en = !valid_q || bus.out_ready;
        end else begin : g_en
            assign en = !valid_q || g_stage[g+1].en;
        end

        assign unused_ctl = ^{mode_q, shamt_q};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                lost_q  <= 1'b0;
                mode_q  <= SRL;
                shamt_q <= '0;
                user_q  <= '0;
            end else if (en) begin
                valid_q <= up_valid;
                if (up_valid) begin
                    data_q  <= data_d;
                    lost_q  <= lost_d;
                    mode_q  <= mode_d;
                    shamt_q <= shamt_d;
                    user_q  <= user_d;
                end
            end
        end
    end

    assign bus.in_ready  = g_stage[0].en;
    assign bus.out_valid = g_stage[PIPE_STAGES-1].valid_q;
    assign bus.out_data  = g_stage[PIPE_STAGES-1].data_q;
    assign bus.out_lost  = g_stage[PIPE_STAGES-1].lost_q;
    assign bus.out_user  = g_stage[PIPE_STAGES-1].user_q;

endmodule

// File: tb/tb_shifter_pipe.sv
// Self-checking bench for shifter_pipe: directed vector table, backpressure,
// random streaming and mid-flight reset, all checked through a scoreboard.
module tb_shifter_pipe;
    import shifter_pkg::*;

    localparam int W  = 48;
    localparam int SH = 8;
    localparam int PS = 2;
    localparam int UW = 8;

    typedef struct {
        logic [1:0]   mode;
        logic [SH-1:0] shamt;
        logic [W-1:0] data;
        logic [W-1:0] exp_data;
        logic         exp_lost;
    } vec_t;

    typedef struct {
        logic [W-1:0]  data;
        logic          lost;
        logic [UW-1:0] user;
        int            cyc;
        bit            chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t tbl[11];

    shifter_pipe_if #(.WIDTH(W), .SHW(SH), .USER_W(UW)) bus ();

    shifter_pipe #(
        .WIDTH       (W),
        .SHW         (SH),
        .PIPE_STAGES (PS),
        .USER_W      (UW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h required=%0h", nm, got, exp);
        end
    endfunction

    function automatic logic [W:0] model(input logic [W-1:0] d, input logic [SH-1:0] sh, input logic [1:0] m);
        int s;
        logic [W-1:0] ones;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [W-1:0] r;
        logic l;
        ones = '1;
        s  = (sh >= W) ? W : int'(sh);
        lo = (s == 0) ? '0 : (ones >> (W - s));
        hi = (s == 0) ? '0 : (ones << (W - s));
        case (m)
            2'd1: begin
                r = $signed(d) >>> s;
                l = (sh >= W) ? |d[W-2:0] : |(d & lo);
            end
            2'd2: begin
                r = d << s;
                l = |(d & hi);
            end
            default: begin
                r = d >> s;
                l = |(d & lo);
            end
        endcase
        return {l, r};
    endfunction

    function automatic void push_exp(input logic [W-1:0] d, input logic l, input logic [UW-1:0] u, input bit lat);
        exp_t e;
        e.data = d; e.lost = l; e.user = u; e.cyc = cyc; e.chk_lat = lat;
        sb.push_back(e);
    endfunction

    function automatic void push(input logic [W-1:0] d, input logic [SH-1:0] sh, input logic [1:0] m,
                                 input logic [UW-1:0] u, input bit lat);
        logic [W:0] r;
        r = model(d, sh, m);
        push_exp(r[W-1:0], r[W], u, lat);
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] d, input logic [SH-1:0] sh,
                         input logic [1:0] m, input logic [UW-1:0] u);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_shamt = sh;
        bus.in_mode  = shift_mode_e'(m);
        bus.in_user  = u;
    endtask

    task automatic offer(input logic [W-1:0] d, input logic [SH-1:0] sh, input logic [1:0] m,
                         input logic [UW-1:0] u, input bit lat);
        bit done = 1'b0;
        drive(1'b1, d, sh, m, u);
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                push(d, sh, m, u, lat);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("offer_accepted", 64'(done), 64'd1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL out_unexpected got data=%h user=%0h required no beat", bus.out_data, bus.out_user);
                end else begin
                    e = sb.pop_front();
                    if (bus.out_data !== e.data || bus.out_lost !== e.lost || bus.out_user !== e.user) begin
                        n_err++;
                        $display("FAIL out_beat got data=%h lost=%0b user=%0h required data=%h lost=%0b user=%0h",
                                 bus.out_data, bus.out_lost, bus.out_user, e.data, e.lost, e.user);
                    end
                    if (e.chk_lat) chk("latency", 64'(cyc - e.cyc), 64'(PS));
                end
            end
        end
    endtask

    logic [W-1:0]  rd;
    logic [SH-1:0] rs;
    logic [1:0]    rm;

    task automatic rand_beat();
        rd = {$urandom, $urandom};
        rs = ($urandom_range(0, 9) == 0) ? SH'($urandom_range(W, 255)) : SH'($urandom_range(0, W - 1));
        rm = 2'($urandom_range(0, 3));
    endtask

    initial begin
        logic [W-1:0]  bp_d[4];
        logic [SH-1:0] bp_s[4];
        logic [1:0]    bp_m[4];
        logic [W-1:0]  held;
        bit            have;
        int            idx;
        int            gaps;
        int            stalls;
        int            stale;

        tbl[0]  = '{2'd0, 8'd4,   48'h0000_0000_00FF, 48'h0000_0000_000F, 1'b1};
        tbl[1]  = '{2'd0, 8'd0,   48'h0000_0000_00FF, 48'h0000_0000_00FF, 1'b0};
        tbl[2]  = '{2'd1, 8'd47,  48'h8000_0000_0000, 48'hFFFF_FFFF_FFFF, 1'b0};
        tbl[3]  = '{2'd1, 8'd200, 48'h8000_0000_0000, 48'hFFFF_FFFF_FFFF, 1'b0};
        tbl[4]  = '{2'd2, 8'd48,  48'h0000_0000_0001, 48'h0000_0000_0000, 1'b1};
        tbl[5]  = '{2'd2, 8'd1,   48'h4000_0000_0000, 48'h8000_0000_0000, 1'b0};
        tbl[6]  = '{2'd3, 8'd4,   48'h0000_0000_0010, 48'h0000_0000_0001, 1'b0};
        tbl[7]  = '{2'd0, 8'd255, 48'h0000_0000_00FF, 48'h0000_0000_0000, 1'b1};
        tbl[8]  = '{2'd1, 8'd48,  48'h7FFF_FFFF_FFFF, 48'h0000_0000_0000, 1'b1};
        tbl[9]  = '{2'd2, 8'd47,  48'h8000_0000_0001, 48'h8000_0000_0000, 1'b1};
        tbl[10] = '{2'd1, 8'd8,   48'hFFFF_FFFF_FF00, 48'hFFFF_FFFF_FFFF, 1'b0};

        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0, 2'd0, '0);
        fork monitor(); join_none

        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_lost", 64'(bus.out_lost), 64'd0);
        chk("rst_out_user", 64'(bus.out_user), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed vectors, one at a time, with exact latency checks.
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, tbl[i].data, tbl[i].shamt, tbl[i].mode, UW'(8'h20 + i));
            @(negedge clk);
            chk("vec_in_ready", 64'(bus.in_ready), 64'd1);
            push_exp(tbl[i].exp_data, tbl[i].exp_lost, UW'(8'h20 + i), 1'b1);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            chk("vec_lat_early", 64'(bus.out_valid), 64'd0);
            @(posedge clk); #1;
            chk("vec_lat", 64'(bus.out_valid), 64'd1);
            @(posedge clk); #1;
        end
        wait_drain();

        // Backpressure: four beats offered against a stalled output.
        for (int i = 0; i < 4; i++) begin
            rand_beat();
            bp_d[i] = rd; bp_s[i] = rs; bp_m[i] = rm;
        end
        bus.out_ready = 1'b0;
        idx = 0; have = 1'b0; held = '0;
        for (int c = 0; c < 6; c++) begin
            drive(idx < 4, bp_d[idx % 4], bp_s[idx % 4], bp_m[idx % 4], UW'(idx + 1));
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                push(bp_d[idx], bp_s[idx], bp_m[idx], UW'(idx + 1), 1'b0);
                idx++;
            end
            if (bus.out_valid) begin
                if (!have) begin
                    held = bus.out_data;
                    have = 1'b1;
                end else begin
                    chk("bp_hold", 64'(bus.out_data), 64'(held));
                end
            end
            @(posedge clk); #1;
        end
        chk("bp_accepted", 64'(idx), 64'd2);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        gaps = 0;
        for (int c = 0; c < 8; c++) begin
            drive(idx < 4, bp_d[idx % 4], bp_s[idx % 4], bp_m[idx % 4], UW'(idx + 1));
            @(negedge clk);
            if (c < 4 && !bus.out_valid) gaps++;
            if (bus.in_valid && bus.in_ready) begin
                push(bp_d[idx], bp_s[idx], bp_m[idx], UW'(idx + 1), 1'b0);
                idx++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("bp_total", 64'(idx), 64'd4);
        chk("bp_gaps", 64'(gaps), 64'd0);
        wait_drain();

        // Full-rate random stream.
        idx = 0; stalls = 0;
        rand_beat();
        for (int c = 0; c < 300 && idx < 100; c++) begin
            drive(1'b1, rd, rs, rm, UW'(idx));
            @(negedge clk);
            if (bus.in_ready) begin
                push(rd, rs, rm, UW'(idx), 1'b1);
                idx++;
                rand_beat();
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("stream_count", 64'(idx), 64'd100);
        chk("stream_stalls", 64'(stalls), 64'd0);
        wait_drain();

        // Reset with two beats in flight.
        bus.out_ready = 1'b0;
        offer(48'h1234_5678_9ABC, 8'd3, 2'd0, 8'hA1, 1'b0);
        offer(48'hFEDC_BA98_7654, 8'd5, 2'd2, 8'hA2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        chk("rst_no_stale", 64'(stale), 64'd0);
        @(posedge clk); #1;
        offer(48'h8000_0000_00F0, 8'd4, 2'd1, 8'hB3, 1'b1);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
